instr_mem_loader: RTL and testbench

Program loader that writes the instruction memory the fetch path reads. Accepts instruction fields over a valid/ready handshake, packs them into the 8-bit instruction word the fetch-side decoder unpacks, and issues sequential writes starting at address 0. A load session runs from `start` until an instruction tagged `in_last` is written or memory capacity is reached.

---
 rtl/instr_mem_loader_if.sv | 30 +++
 rtl/instr_mem_loader.sv | 100 ++++++++++
 tb/tb_instr_mem_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Handshake and write-bus bundle between a program source and the instruction memory loader.
interface instr_mem_loader_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic       in_rd;
    logic       in_rs;
    logic [2:0] in_imm;
    logic [4:0] in_address;
    logic       in_fmt_addr;
    logic       in_last;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] count;
    logic       overflow;

    modport master (
        output start, in_valid, in_opcode, in_rd, in_rs, in_imm, in_address, in_fmt_addr, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, count, overflow
    );

    modport slave (
        input  start, in_valid, in_opcode, in_rd, in_rs, in_imm, in_address, in_fmt_addr, in_last,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, count, overflow
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs instruction fields into 8-bit words and writes them sequentially from address 0
// until an in_last word is written or memory capacity is reached.
module instr_mem_loader #(
    parameter int MAX_WORDS = 32
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(MAX_WORDS - 1);
    // count is 8 bits wide, so a 256-word memory saturates it at 255
    localparam logic [7:0] CNT_MAX  = 8'((MAX_WORDS > 255) ? 255 : MAX_WORDS);

    state_t     state, state_nxt;
    logic [7:0] ptr;
    logic [7:0] cnt;
    logic       ovf;
    logic       accept;
    logic       at_cap;
    logic [7:0] pack;
    logic       wr_en_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: begin
                if (bus.start)                   state_nxt = LOAD;
                else if (accept && bus.in_last)  state_nxt = DONE;
                else if (accept && at_cap)       state_nxt = FULL;
            end
            FULL: if (bus.start) state_nxt = LOAD;
            DONE: state_nxt = bus.start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == LOAD) && !bus.start;
        accept       = bus.in_valid && bus.in_ready;
        at_cap       = (ptr == LAST_IDX);
        pack         = bus.in_fmt_addr ? {bus.in_opcode, bus.in_address}
                                       : {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm};
    end

    // busy follows the state being entered; done trails the DONE state by one cycle
    // so it lands after the final write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == LOAD) || (state_nxt == FULL);
            done_q <= (state == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (bus.start) begin
                ptr <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                wr_addr_q <= ptr;
                wr_data_q <= pack;
                if (!at_cap)          ptr <= ptr + 8'd1;
                if (cnt != CNT_MAX)   cnt <= cnt + 8'd1;
                if (at_cap && !bus.in_last) ovf <= 1'b1;
            end
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a 4-word memory.
module tb_instr_mem_loader;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if bus();
    instr_mem_loader #(.MAX_WORDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    logic [7:0] ovf_data [4] = '{8'h2B, 8'h4B, 8'h6B, 8'h8B};
    logic [7:0] stl_data [3] = '{8'h87, 8'h21, 8'h78};

    always @(negedge clk) begin
        cyc++;
        if (bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic put(input logic [2:0] op, input logic rd, input logic rs, input logic [2:0] imm,
                       input logic [4:0] adr, input logic fmt, input logic last);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = op;
        bus.in_rd       = rd;
        bus.in_rs       = rs;
        bus.in_imm      = imm;
        bus.in_address  = adr;
        bus.in_fmt_addr = fmt;
        bus.in_last     = last;
    endtask

    task automatic hold();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        #1 chk("rdy_lo_on_start", bus.in_ready, 0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        put(3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        hold();
        repeat (2) @(negedge clk);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdy", bus.in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rdy", bus.in_ready, 0);

        // register word then address word with last
        pulse_start();
        chk("start_rdy", bus.in_ready, 1);
        chk("start_busy", bus.busy, 1);
        put(3'b010, 1'b1, 1'b0, 3'b101, 5'h1F, 1'b0, 1'b0);
        @(negedge clk);
        chk("w0_en", bus.wr_en, 1);
        chk("w0_addr", bus.wr_addr, 0);
        chk("w0_data", bus.wr_data, 8'b0101_0101);
        chk("w0_count", bus.count, 1);
        put(3'b111, 1'b1, 1'b1, 3'b111, 5'b10011, 1'b1, 1'b1);
        @(negedge clk);
        hold();
        #1;
        chk("w1_en", bus.wr_en, 1);
        chk("w1_addr", bus.wr_addr, 1);
        chk("w1_data", bus.wr_data, 8'b1111_0011);
        chk("w1_done_early", bus.done, 0);
        chk("w1_rdy_lo", bus.in_ready, 0);
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("done_wr_en", bus.wr_en, 0);
        chk("done_count", bus.count, 2);
        chk("done_ovf", bus.overflow, 0);
        chk("done_busy", bus.busy, 0);
        @(negedge clk);
        chk("done_gone", bus.done, 0);

        // stall: valid 1,0,1,1
        pulse_start();
        clr_log();
        put(3'b100, 1'b0, 1'b0, 3'b111, 5'h1F, 1'b0, 1'b0);
        @(negedge clk);
        hold();
        @(negedge clk);
        put(3'b001, 1'b1, 1'b1, 3'b111, 5'b00001, 1'b1, 1'b0);
        @(negedge clk);
        put(3'b011, 1'b1, 1'b1, 3'b000, 5'h0A, 1'b0, 1'b1);
        @(negedge clk);
        hold();
        repeat (2) @(negedge clk);
        chk("stall_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("stall_addr%0d", i), wa[i], i);
                chk($sformatf("stall_data%0d", i), wd[i], stl_data[i]);
            end
            chk("stall_gap01", wc[1] - wc[0], 2);
            chk("stall_gap12", wc[2] - wc[1], 1);
        end

        // overflow: 5 words, no last, capacity 4
        pulse_start();
        clr_log();
        for (int i = 0; i < 5; i++) begin
            put(3'(i + 1), 1'b0, 1'b1, 3'b011, 5'd0, 1'b0, 1'b0);
            #1 chk($sformatf("ovf_rdy%0d", i), bus.in_ready, (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        hold();
        #1;
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_count", bus.count, 4);
        chk("ovf_busy", bus.busy, 1);
        chk("ovf_done", bus.done, 0);
        repeat (2) @(negedge clk);
        chk("ovf_nwr", wa.size(), 4);
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_addr%0d", i), wa[i], i);
                chk($sformatf("ovf_data%0d", i), wd[i], ovf_data[i]);
            end
        end
        pulse_start();
        chk("restart_ovf", bus.overflow, 0);
        chk("restart_count", bus.count, 0);
        chk("restart_rdy", bus.in_ready, 1);
        put(3'b010, 1'b1, 1'b0, 3'b101, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        hold();
        #1;
        chk("restart_addr", bus.wr_addr, 0);
        chk("restart_data", bus.wr_data, 8'h55);
        repeat (2) @(negedge clk);

        // last on the capacity word
        pulse_start();
        clr_log();
        for (int i = 0; i < 4; i++) begin
            put(3'b110, 1'b0, 1'b0, 3'd0, 5'(i), 1'b1, i == 3);
            @(negedge clk);
        end
        hold();
        #1;
        chk("cap_last_count", bus.count, 4);
        chk("cap_last_ovf", bus.overflow, 0);
        @(negedge clk);
        chk("cap_last_done", bus.done, 1);
        chk("cap_last_nwr", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("cap_last_addr3", wa[3], 3);
            chk("cap_last_data3", wd[3], 8'hC3);
        end
        @(negedge clk);

        // reset during the second write strobe
        pulse_start();
        put(3'b010, 1'b1, 1'b0, 3'b101, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        put(3'b001, 1'b0, 1'b0, 3'b001, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        hold();
        #1 chk("pre_rst_wr_en", bus.wr_en, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_addr", bus.wr_addr, 0);
        chk("mid_rst_data", bus.wr_data, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rdy", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        put(3'b111, 1'b0, 1'b0, 3'd0, 5'b00110, 1'b1, 1'b1);
        @(negedge clk);
        hold();
        #1;
        chk("post_rst_en", bus.wr_en, 1);
        chk("post_rst_addr", bus.wr_addr, 0);
        chk("post_rst_data", bus.wr_data, 8'hE6);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
